regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_pkg.sv | 10 +
 rtl/regfile_scoreboard_if.sv | 37 +++
 rtl/regfile_rdport.sv | 39 +++
 rtl/regfile_scoreboard.sv | 132 +++++++++++++
 tb/tb_regfile_scoreboard.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared default sizing for the register file scoreboard
// Contents: default data width, address width and read-port count used as
// parameter defaults by the interface, the read port and the top level.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// rtl/regfile_scoreboard_if.sv - read/writeback/allocate bus of the register file scoreboard
// Signals:
//   rd_addr/rd_data/rd_busy          packed read ports, port i uses slice i
//   we/wr_addr/wr_data               writeback
//   alloc_en/alloc_addr/alloc_ok     busy-bit allocation request and grant
//   flush                            clear all busy bits
//   busy_count                       number of busy registers
// Modports: master drives requests (pipeline side), slave is the register file.
interface regfile_scoreboard_if import regfile_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
);

    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     we;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     alloc_en;
    logic [ADDR_W-1:0]        alloc_addr;
    logic                     alloc_ok;
    logic                     flush;
    logic [ADDR_W:0]          busy_count;

    modport master (
        output rd_addr, we, wr_addr, wr_data, alloc_en, alloc_addr, flush,
        input  rd_data, rd_busy, alloc_ok, busy_count
    );

    modport slave (
        input  rd_addr, we, wr_addr, wr_data, alloc_en, alloc_addr, flush,
        output rd_data, rd_busy, alloc_ok, busy_count
    );

endinterface

// File: rtl/regfile_rdport.sv
// rtl/regfile_rdport.sv - one read port: storage mux, writeback bypass and busy lookup
// Ports:
//   addr       register to read
//   regs       register storage contents
//   busy       scoreboard busy bits, one per register
//   we/wr_addr/wr_data  writeback happening this cycle (bypass source)
//   data       read data (combinational)
//   data_busy  busy flag of the addressed register (combinational)
module regfile_rdport import regfile_pkg::*; #(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DATA_W-1:0]      regs [2**ADDR_W],
    input  logic [2**ADDR_W-1:0]   busy,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    output logic [DATA_W-1:0]      data,
    output logic                   data_busy
);

    always_comb begin
        data      = regs[addr];
        data_busy = busy[addr];
        if ((ZERO_R0 != 0) && (addr == '0)) begin
            // r0 is a constant: never forwarded, never busy
            data      = '0;
            data_busy = 1'b0;
        end else if ((BYPASS != 0) && we && (wr_addr == addr)) begin
            // the value is arriving this cycle, so the consumer need not wait
            data      = wr_data;
            data_busy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with per-register busy scoreboard
// Ports:
//   clock  sole clock, rising edge
//   Reset  asynchronous active-low reset; clears storage, busy bits and count
//   bus    regfile_scoreboard_if.slave: NUM_RD read ports, writeback,
//          allocation request/grant, flush and busy_count
module regfile_scoreboard import regfile_pkg::*; #(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int NUM_RD  = DEF_NUM_RD,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic                  clock,
    input  logic                  Reset,
    regfile_scoreboard_if.slave   bus
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;

    logic wr_is_r0;
    logic alloc_is_r0;
    logic wr_en;
    logic alloc_meets_wb;
    logic alloc_ok;
    logic cnt_inc;
    logic cnt_dec;

    assign wr_is_r0    = (ZERO_R0 != 0) && (bus.wr_addr == '0);
    assign alloc_is_r0 = (ZERO_R0 != 0) && (bus.alloc_addr == '0);
    assign wr_en       = bus.we && !wr_is_r0;

    // A busy target may be re-allocated in the very cycle its pending write lands
    assign alloc_meets_wb = bus.we && (bus.wr_addr == bus.alloc_addr);

    assign alloc_ok = Reset && bus.alloc_en && !bus.flush && !alloc_is_r0 &&
                      (!busy[bus.alloc_addr] || alloc_meets_wb);

    // Counter moves only when a busy bit actually changes value:
    // re-allocating a busy register that is being written back is net zero.
    assign cnt_inc = alloc_ok && !busy[bus.alloc_addr];
    assign cnt_dec = bus.we && busy[bus.wr_addr] && !(alloc_ok && alloc_meets_wb);

    always_comb begin
        busy_d = busy;
        if (bus.flush) begin
            busy_d = '0;
        end else begin
            if (bus.we) begin
                busy_d[bus.wr_addr] = 1'b0;
            end
            // set after clear so a same-register alloc keeps the bit
            if (alloc_ok) begin
                busy_d[bus.alloc_addr] = 1'b1;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (bus.flush) begin
            count_d = '0;
        end else if (cnt_inc && !cnt_dec) begin
            count_d = count_q + CNT_W'(1);
        end else if (cnt_dec && !cnt_inc) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs[k] <= '0;
            end
        end else if (wr_en) begin
            // the storage write proceeds even when flush is asserted
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            busy    <= '0;
            count_q <= '0;
        end else begin
            busy    <= busy_d;
            count_q <= count_d;
        end
    end

    logic [DATA_W-1:0] port_data [NUM_RD];
    logic              port_busy [NUM_RD];

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        regfile_rdport #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .ZERO_R0 (ZERO_R0),
            .BYPASS  (BYPASS)
        ) u_rdport (
            .addr      (bus.rd_addr[i*ADDR_W +: ADDR_W]),
            .regs      (regs),
            .busy      (busy),
            .we        (bus.we),
            .wr_addr   (bus.wr_addr),
            .wr_data   (bus.wr_data),
            .data      (port_data[i]),
            .data_busy (port_busy[i])
        );
    end

    // Reset also masks the bypass path so nothing leaks out while held in reset
    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            bus.rd_data[i*DATA_W +: DATA_W] = Reset ? port_data[i] : '0;
            bus.rd_busy[i]                  = Reset && port_busy[i];
        end
    end

    assign bus.alloc_ok   = alloc_ok;
    assign bus.busy_count = count_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - self-checking bench for regfile_scoreboard
module tb_regfile_scoreboard;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic clock = 1'b0;
    logic Reset = 1'b0;

    always #5 clock = ~clock;

    regfile_scoreboard_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

    regfile_scoreboard #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_R0(1), .BYPASS(1)
    ) dut (
        .clock (clock),
        .Reset (Reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // current stimulus, mirrored for the reference model
    logic        t_we, t_ae, t_fl;
    logic [4:0]  t_wa, t_aa, t_ra0, t_ra1;
    logic [31:0] t_wd;

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic ae, input logic [4:0] aa, input logic fl,
                         input logic [4:0] ra0, input logic [4:0] ra1);
        t_we = we; t_wa = wa; t_wd = wd; t_ae = ae; t_aa = aa; t_fl = fl;
        t_ra0 = ra0; t_ra1 = ra1;
        bus.we = we; bus.wr_addr = wa; bus.wr_data = wd;
        bus.alloc_en = ae; bus.alloc_addr = aa; bus.flush = fl;
        bus.rd_addr = {ra1, ra0};
    endtask

    // reference model: architectural register values and set of pending writes
    logic [31:0] m_regs [32];
    bit          m_busy [32];

    function automatic void m_reset();
        for (int k = 0; k < 32; k++) begin
            m_regs[k] = '0;
            m_busy[k] = 1'b0;
        end
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int k = 0; k < 32; k++) c += int'(m_busy[k]);
        return c;
    endfunction

    function automatic logic m_ok();
        if (!t_ae || t_fl || t_aa == 5'd0) return 1'b0;
        return !m_busy[t_aa] || (t_we && t_wa == t_aa);
    endfunction

    function automatic logic [31:0] m_rd(input logic [4:0] ra);
        if (ra == 5'd0) return 32'd0;
        if (t_we && t_wa == ra) return t_wd;
        return m_regs[ra];
    endfunction

    function automatic logic m_rb(input logic [4:0] ra);
        if (ra == 5'd0) return 1'b0;
        if (t_we && t_wa == ra) return 1'b0;
        return m_busy[ra];
    endfunction

    function automatic void m_commit(input logic ok);
        if (t_we && t_wa != 5'd0) m_regs[t_wa] = t_wd;
        if (t_fl) begin
            for (int k = 0; k < 32; k++) m_busy[k] = 1'b0;
        end else begin
            if (t_we) m_busy[t_wa] = 1'b0;
            if (ok) m_busy[t_aa] = 1'b1;
        end
    endfunction

    function automatic logic [4:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        ae;
        logic [4:0]  aa;
        logic        fl;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic        x_ok;
        logic [31:0] x_d0;
        logic [31:0] x_d1;
        logic        x_b0;
        logic        x_b1;
        int          x_cnt;
    } vec_t;

    vec_t vecs [14];

    initial begin
        vec_t v;
        logic ok_e;

        vecs[0]  = '{1'b1, 5'd5, 32'h1234ABCD, 1'b0, 5'd0, 1'b0, 5'd5, 5'd5, 1'b0, 32'h1234ABCD, 32'h1234ABCD, 1'b0, 1'b0, 0};
        vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd5, 5'd5, 1'b0, 32'h1234ABCD, 32'h1234ABCD, 1'b0, 1'b0, 0};
        vecs[2]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 1'b0, 5'd0, 5'd5, 1'b0, 32'h0,        32'h1234ABCD, 1'b0, 1'b0, 0};
        vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 0};
        vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 1'b0, 5'd7, 5'd5, 1'b1, 32'h0,        32'h1234ABCD, 1'b0, 1'b0, 1};
        vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 1'b0, 5'd7, 5'd7, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 1};
        vecs[6]  = '{1'b1, 5'd7, 32'hA5A50007, 1'b0, 5'd0, 1'b0, 5'd7, 5'd5, 1'b0, 32'hA5A50007, 32'h1234ABCD, 1'b0, 1'b0, 0};
        vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd7, 5'd7, 1'b0, 32'hA5A50007, 32'hA5A50007, 1'b0, 1'b0, 0};
        vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 1'b0, 5'd7, 5'd5, 1'b1, 32'hA5A50007, 32'h1234ABCD, 1'b0, 1'b0, 1};
        vecs[9]  = '{1'b1, 5'd7, 32'h00000077, 1'b1, 5'd7, 1'b0, 5'd7, 5'd7, 1'b1, 32'h00000077, 32'h00000077, 1'b0, 1'b0, 1};
        vecs[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd7, 5'd5, 1'b0, 32'h00000077, 32'h1234ABCD, 1'b1, 1'b0, 1};
        vecs[11] = '{1'b1, 5'd7, 32'h00000088, 1'b0, 5'd0, 1'b0, 5'd5, 5'd7, 1'b0, 32'h1234ABCD, 32'h00000088, 1'b0, 1'b0, 0};
        vecs[12] = '{1'b1, 5'd9, 32'h00000099, 1'b1, 5'd9, 1'b1, 5'd9, 5'd9, 1'b0, 32'h00000099, 32'h00000099, 1'b0, 1'b0, 0};
        vecs[13] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd9, 5'd7, 1'b0, 32'h00000099, 32'h00000088, 1'b0, 1'b0, 0};

        // held in reset: outputs quiet even with live requests
        drive(1'b1, 5'd5, 32'hCAFEF00D, 1'b1, 5'd3, 1'b0, 5'd5, 5'd5);
        #3;
        check("reset busy_count", 32'(bus.busy_count), 32'd0);
        check("reset alloc_ok", 32'(bus.alloc_ok), 32'd0);
        check("reset rd_data0", bus.rd_data[31:0], 32'd0);
        check("reset rd_data1", bus.rd_data[63:32], 32'd0);
        @(posedge clock); #1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        #2 Reset = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 14; i++) begin
            v = vecs[i];
            drive(v.we, v.wa, v.wd, v.ae, v.aa, v.fl, v.ra0, v.ra1);
            #2;
            check($sformatf("vec%0d alloc_ok", i), 32'(bus.alloc_ok), 32'(v.x_ok));
            check($sformatf("vec%0d rd_data0", i), bus.rd_data[31:0], v.x_d0);
            check($sformatf("vec%0d rd_data1", i), bus.rd_data[63:32], v.x_d1);
            check($sformatf("vec%0d rd_busy0", i), 32'(bus.rd_busy[0]), 32'(v.x_b0));
            check($sformatf("vec%0d rd_busy1", i), 32'(bus.rd_busy[1]), 32'(v.x_b1));
            @(posedge clock); #1;
            check($sformatf("vec%0d busy_count", i), 32'(bus.busy_count), 32'(v.x_cnt));
        end

        // fill every allocatable register
        for (int a = 1; a < 32; a++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(a), 1'b0, 5'(a), 5'd0);
            #2;
            check($sformatf("fill r%0d alloc_ok", a), 32'(bus.alloc_ok), 32'd1);
            @(posedge clock); #1;
        end
        check("full busy_count", 32'(bus.busy_count), 32'd31);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b0, 5'd31, 5'd3);
        #2;
        check("full alloc r0", 32'(bus.alloc_ok), 32'd0);
        check("full rd_busy r31", 32'(bus.rd_busy[0]), 32'd1);
        check("full rd_busy r3", 32'(bus.rd_busy[1]), 32'd1);
        @(posedge clock); #1;
        check("full count capped", 32'(bus.busy_count), 32'd31);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b1, 5'd3, 5'd31);
        #2;
        check("flush alloc_ok", 32'(bus.alloc_ok), 32'd0);
        @(posedge clock); #1;
        check("flush busy_count", 32'(bus.busy_count), 32'd0);
        check("flush rd_busy r3", 32'(bus.rd_busy[0]), 32'd0);

        // asynchronous reset between edges with four busy registers
        for (int a = 1; a <= 4; a++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(a), 1'b0, 5'd0, 5'd0);
            @(posedge clock); #1;
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd2);
        #1;
        check("pre-reset busy_count", 32'(bus.busy_count), 32'd4);
        check("pre-reset rd_data r5", bus.rd_data[31:0], 32'h1234ABCD);
        check("pre-reset rd_busy r2", 32'(bus.rd_busy[1]), 32'd1);
        #1 Reset = 1'b0;
        #1;
        check("async reset busy_count", 32'(bus.busy_count), 32'd0);
        check("async reset rd_data0", bus.rd_data[31:0], 32'd0);
        check("async reset rd_busy1", 32'(bus.rd_busy[1]), 32'd0);
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd12, 1'b0, 5'd5, 5'd2);
        #1;
        check("in reset bypass", bus.rd_data[31:0], 32'd0);
        check("in reset alloc_ok", 32'(bus.alloc_ok), 32'd0);
        @(posedge clock); #1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd9);
        #2 Reset = 1'b1;
        #1;
        check("post-reset r5", bus.rd_data[31:0], 32'd0);
        check("post-reset r9", bus.rd_data[63:32], 32'd0);
        check("post-reset busy_count", 32'(bus.busy_count), 32'd0);
        @(posedge clock); #1;

        // randomized traffic against the reference model
        m_reset();
        for (int n = 0; n < 1500; n++) begin
            drive(1'($urandom_range(0, 1)), rand_addr(), $urandom(),
                  1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 39) == 0),
                  rand_addr(), rand_addr());
            ok_e = m_ok();
            #2;
            check($sformatf("rnd%0d alloc_ok", n), 32'(bus.alloc_ok), 32'(ok_e));
            check($sformatf("rnd%0d rd_data0", n), bus.rd_data[31:0], m_rd(t_ra0));
            check($sformatf("rnd%0d rd_data1", n), bus.rd_data[63:32], m_rd(t_ra1));
            check($sformatf("rnd%0d rd_busy0", n), 32'(bus.rd_busy[0]), 32'(m_rb(t_ra0)));
            check($sformatf("rnd%0d rd_busy1", n), 32'(bus.rd_busy[1]), 32'(m_rb(t_ra1)));
            @(posedge clock); #1;
            m_commit(ok_e);
            check($sformatf("rnd%0d busy_count", n), 32'(bus.busy_count), 32'(m_count()));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
